// File: rtl/perc_sweep_gen.sv
// perc_sweep_gen: multi-channel percussion voice with falling-pitch sweep and stepped envelope.
// Define PERC_NOISE_EN to add LFSR pitch jitter (0..127) on snare and hi-hat channels.
module perc_sweep_gen #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned FREQ_W      = 32,
   parameter int unsigned SILENCE     = 100000000,
   parameter int unsigned ENV_DIV     = 4,
   parameter int unsigned KICK_START  = 150,
   parameter int unsigned KICK_FLOOR  = 20,
   parameter int unsigned KICK_STEP   = 10,
   parameter int unsigned SNARE_START = 250,
   parameter int unsigned SNARE_FLOOR = 150,
   parameter int unsigned SNARE_STEP  = 10,
   parameter int unsigned HAT_START   = 6000,
   parameter int unsigned HAT_FLOOR   = 4000,
   parameter int unsigned HAT_STEP    = 250
) (
   input  logic                  clkDiv22,
   input  logic                  rst,
   input  logic [2*NCH-1:0]      beat_code,
   input  logic [NCH-1:0]        retrig,
   output logic [FREQ_W*NCH-1:0] freq,
   output logic [3*NCH-1:0]      env,
   output logic [NCH-1:0]        active
);

   localparam int unsigned       DIV_W    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam logic [FREQ_W-1:0] SIL      = FREQ_W'(SILENCE);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ENV_DIV - 1);

   logic [6:0] jitter;

`ifdef PERC_NOISE_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16/14/13/11, shared by all channels.
   always_ff @(posedge clkDiv22 or posedge rst) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign jitter = lfsr_q[6:0];
`else
   assign jitter = '0;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [1:0]        code;
      logic              load;
      logic [1:0]        prev_code_q, prev_code_d;
      logic [1:0]        kind_q, kind_d;
      logic [FREQ_W-1:0] f_q, f_d;
      logic [2:0]        env_q, env_d;
      logic [DIV_W-1:0]  div_q, div_d;
      logic              active_q, active_d;
      logic [FREQ_W-1:0] start_f, floor_f, step_f, jit_f;

      assign code = beat_code[2*i +: 2];
      assign load = (code != prev_code_q) || retrig[i];

      always_comb begin
         unique case (code)
            2'd1:    start_f = FREQ_W'(KICK_START);
            2'd2:    start_f = FREQ_W'(SNARE_START);
            2'd3:    start_f = FREQ_W'(HAT_START);
            default: start_f = SIL;
         endcase
      end

      always_comb begin
         unique case (kind_q)
            2'd1:    begin floor_f = FREQ_W'(KICK_FLOOR);  step_f = FREQ_W'(KICK_STEP);  end
            2'd2:    begin floor_f = FREQ_W'(SNARE_FLOOR); step_f = FREQ_W'(SNARE_STEP); end
            2'd3:    begin floor_f = FREQ_W'(HAT_FLOOR);   step_f = FREQ_W'(HAT_STEP);   end
            default: begin floor_f = '0;                   step_f = '0;                  end
         endcase
      end

      always_comb begin
         // NOTE: every target gets its hold value first, so no branch can infer a latch.
         prev_code_d = prev_code_q;
         kind_d      = kind_q;
         f_d         = f_q;
         env_d       = env_q;
         div_d       = div_q;
         active_d    = active_q;
         if (load) begin
            prev_code_d = code;
            kind_d      = code;
            div_d       = '0;
            if (code != 2'd0) begin
               f_d      = start_f;
               env_d    = 3'd7;
               active_d = 1'b1;
            end else begin
               f_d      = SIL;
               env_d    = '0;
               active_d = 1'b0;
            end
         end else if (active_q) begin
            // Saturating sweep: compare the headroom, never subtract past the floor.
            if (f_q > floor_f && (f_q - floor_f) > step_f) f_d = f_q - step_f;
            else                                           f_d = floor_f;
            if (div_q == DIV_LAST) begin
               div_d = '0;
               env_d = env_q - 3'd1;
               if (env_q == 3'd1) begin
                  active_d = 1'b0;
                  f_d      = SIL;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
      end

      // NOTE: state registers use non-blocking assignments so every channel samples pre-edge values.
      always_ff @(posedge clkDiv22 or posedge rst) begin
         if (rst) begin
            prev_code_q <= '0;
            kind_q      <= '0;
            f_q         <= SIL;
            env_q       <= '0;
            div_q       <= '0;
            active_q    <= 1'b0;
         end else begin
            prev_code_q <= prev_code_d;
            kind_q      <= kind_d;
            f_q         <= f_d;
            env_q       <= env_d;
            div_q       <= div_d;
            active_q    <= active_d;
         end
      end

      assign jit_f = (kind_q == 2'd2 || kind_q == 2'd3) ? f_q + FREQ_W'(jitter) : f_q;
      assign freq[FREQ_W*i +: FREQ_W] = active_q ? jit_f : SIL;
      assign env[3*i +: 3]            = active_q ? env_q : 3'd0;
      assign active[i]                = active_q;
   end

endmodule

// File: tb/tb_perc_sweep_gen.sv
// Scoreboard bench for perc_sweep_gen: the driver queues expected per-channel outputs
// tagged with the tick they belong to; a negedge monitor pops and compares them.
module tb_perc_sweep_gen;

   localparam int          NCH = 4;
   localparam logic [31:0] SIL = 32'd100000000;

   localparam int T_RST = 0, T_KICK = 1, T_SNARE = 2, T_RETRIG = 3, T_ZERO = 4, T_ARST = 5;

   typedef struct packed {
      int          cyc;
      int          ch;
      logic [31:0] f;
      logic [2:0]  ev;
      logic        act;
      logic        jit;
      logic [3:0]  tid;
   } exp_t;

   logic             clkDiv22;
   logic             rst;
   logic [2*NCH-1:0] beat_code;
   logic [NCH-1:0]   retrig;
   logic [32*NCH-1:0] freq;
   logic [3*NCH-1:0] env;
   logic [NCH-1:0]   active;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   L;

   perc_sweep_gen #(.SNARE_STEP(30)) dut (
      .clkDiv22  (clkDiv22),
      .rst       (rst),
      .beat_code (beat_code),
      .retrig    (retrig),
      .freq      (freq),
      .env       (env),
      .active    (active)
   );

   initial begin
      clkDiv22 = 1'b0;
      forever #5 clkDiv22 = ~clkDiv22;
   end

   always @(posedge clkDiv22) cyc <= cyc + 1;

`ifdef PERC_NOISE_EN
   logic [15:0] ref_lfsr;
   always @(posedge clkDiv22 or posedge rst) begin
      if (rst) ref_lfsr <= 16'hACE1;
      else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
   end
`endif

   function automatic string tname(input logic [3:0] t);
      case (t)
         4'(T_RST):    return "reset";
         4'(T_KICK):   return "kick_sweep";
         4'(T_SNARE):  return "snare_clamp";
         4'(T_RETRIG): return "retrig";
         4'(T_ZERO):   return "code_zero";
         default:      return "async_reset";
      endcase
   endfunction

   task automatic push(input int c, input int ch, input int f, input int ev,
                       input bit act, input bit jit, input int tid);
      exp_t x;
      x.cyc = c;
      x.ch  = ch;
      x.f   = f;
      x.ev  = ev[2:0];
      x.act = act;
      x.jit = jit;
      x.tid = tid[3:0];
      sb.push_back(x);
   endtask

   task automatic check(input exp_t x);
      logic [31:0] got_f, want_f;
      logic [2:0]  got_e;
      logic        got_a;
      got_f  = freq[32*x.ch +: 32];
      got_e  = env[3*x.ch +: 3];
      got_a  = active[x.ch];
      want_f = x.f;
`ifdef PERC_NOISE_EN
      if (x.jit && x.act) want_f = x.f + {25'd0, ref_lfsr[6:0]};
`endif
      checks++;
      if (got_f !== want_f || got_e !== x.ev || got_a !== x.act) begin
         errors++;
         $display("FAIL %s ch%0d tick%0d: got freq=%0d env=%0d active=%0d, want freq=%0d env=%0d active=%0d",
                  tname(x.tid), x.ch, x.cyc, got_f, got_e, got_a, want_f, x.ev, x.act);
      end
   endtask

   always @(negedge clkDiv22) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].cyc == cyc) begin
            check(sb[k]);
            sb.delete(k);
         end
      end
   end

   task automatic steps(input int n);
      repeat (n) @(posedge clkDiv22);
      #1;
   endtask

   int kick_f[15] = '{150, 140, 130, 120, 110, 100, 90, 80, 70, 60, 50, 40, 30, 20, 20};
   int kick_e[15] = '{7, 7, 7, 7, 6, 6, 6, 6, 5, 5, 5, 5, 4, 4, 4};
   int snr_f[7]   = '{250, 220, 190, 160, 150, 150, 150};
   int snr_e[7]   = '{7, 7, 7, 7, 6, 6, 6};

   initial begin
      rst       = 1'b1;
      beat_code = '0;
      retrig    = '0;

      // Reset state while rst is held.
      steps(1);
      for (int c = 0; c < NCH; c++) push(cyc + 1, c, SIL, 0, 1'b0, 1'b0, T_RST);
      steps(1);
      @(negedge clkDiv22);
      #1 rst = 1'b0;

      // Kick on ch0: sweep to floor, envelope steps, silence at L+28.
      beat_code[1:0] = 2'd1;
      L = cyc + 1;
      for (int n = 0; n < 15; n++) push(L + n, 0, kick_f[n], kick_e[n], 1'b1, 1'b0, T_KICK);
      push(L + 24, 0, 20, 1, 1'b1, 1'b0, T_KICK);
      push(L + 27, 0, 20, 1, 1'b1, 1'b0, T_KICK);
      push(L + 28, 0, SIL, 0, 1'b0, 1'b0, T_KICK);
      push(L + 31, 0, SIL, 0, 1'b0, 1'b0, T_KICK);
      steps(33);

      // Snare on ch1 with step 30: clamps at 150.
      beat_code[3:2] = 2'd2;
      L = cyc + 1;
      for (int n = 0; n < 7; n++) push(L + n, 1, snr_f[n], snr_e[n], 1'b1, 1'b1, T_SNARE);
      push(L + 28, 1, SIL, 0, 1'b0, 1'b0, T_SNARE);
      steps(30);

      // Hat on ch2 and kick on ch3; at L+5 retrig ch2 and switch ch3 to snare.
      beat_code[5:4] = 2'd3;
      beat_code[7:6] = 2'd1;
      L = cyc + 1;
      push(L,     2, 6000, 7, 1'b1, 1'b1, T_RETRIG);
      push(L + 1, 2, 5750, 7, 1'b1, 1'b1, T_RETRIG);
      push(L + 4, 2, 5000, 6, 1'b1, 1'b1, T_RETRIG);
      push(L + 5, 2, 6000, 7, 1'b1, 1'b1, T_RETRIG);
      push(L + 6, 2, 5750, 7, 1'b1, 1'b1, T_RETRIG);
      push(L + 9, 2, 5000, 6, 1'b1, 1'b1, T_RETRIG);
      push(L,     3, 150,  7, 1'b1, 1'b0, T_RETRIG);
      push(L + 4, 3, 110,  6, 1'b1, 1'b0, T_RETRIG);
      push(L + 5, 3, 250,  7, 1'b1, 1'b1, T_RETRIG);
      push(L + 6, 3, 220,  7, 1'b1, 1'b1, T_RETRIG);
      push(L + 9, 3, 150,  6, 1'b1, 1'b1, T_RETRIG);
      steps(5);
      retrig[2]      = 1'b1;
      beat_code[7:6] = 2'd2;
      steps(1);
      retrig[2] = 1'b0;
      steps(5);

      // Retrig the silent kick on ch0, then drop its code to 0 at L+3.
      retrig[0] = 1'b1;
      L = cyc + 1;
      push(L,     0, 150, 7, 1'b1, 1'b0, T_ZERO);
      push(L + 1, 0, 140, 7, 1'b1, 1'b0, T_ZERO);
      push(L + 2, 0, 130, 7, 1'b1, 1'b0, T_ZERO);
      push(L + 3, 0, SIL, 0, 1'b0, 1'b0, T_ZERO);
      push(L + 5, 0, SIL, 0, 1'b0, 1'b0, T_ZERO);
      steps(1);
      retrig[0] = 1'b0;
      steps(2);
      beat_code[1:0] = 2'd0;
      steps(4);

      // Asynchronous reset mid-sweep, then every non-zero code reloads.
      beat_code[1:0] = 2'd1;
      L = cyc + 1;
      push(L, 0, 150, 7, 1'b1, 1'b0, T_ARST);
      steps(2);
      rst = 1'b1;
      for (int c = 0; c < NCH; c++) push(cyc, c, SIL, 0, 1'b0, 1'b0, T_ARST);
      push(cyc + 1, 0, SIL, 0, 1'b0, 1'b0, T_ARST);
      steps(1);
      @(negedge clkDiv22);
      #1 rst = 1'b0;
      L = cyc + 1;
      push(L,     0, 150,  7, 1'b1, 1'b0, T_ARST);
      push(L,     1, 250,  7, 1'b1, 1'b1, T_ARST);
      push(L,     2, 6000, 7, 1'b1, 1'b1, T_ARST);
      push(L,     3, 250,  7, 1'b1, 1'b1, T_ARST);
      push(L + 1, 0, 140,  7, 1'b1, 1'b0, T_ARST);
      push(L + 1, 1, 220,  7, 1'b1, 1'b1, T_ARST);
      push(L + 1, 2, 5750, 7, 1'b1, 1'b1, T_ARST);
      push(L + 1, 3, 220,  7, 1'b1, 1'b1, T_ARST);
      steps(4);

      if (sb.size() != 0) begin
         errors += sb.size();
         $display("FAIL scoreboard: got %0d unchecked entries, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
